// File: rtl/fft_mix_sched.sv
// Read scheduler for a radix-4 FFT with four parallel banks: issues one common
// read address per cycle and delays the per-butterfly rotation to the mixer.
module fft_mix_sched #(
  parameter int ADDR_W = 4,
  parameter int STAGES = 3,
  parameter int RD_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iHOLD,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oRD_EN,
  output logic [1:0]        oSEL,
  output logic              oMIX_VALID,
  output logic [3:0]        oSTAGE,
  output logic              oBUSY,
  output logic              oDONE
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [3:0] LAST_STAGE = 4'(STAGES - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(RD_LAT);

  state_t            state, state_n;
  logic [ADDR_W-1:0] b, b_n;
  logic [3:0]        s, s_n;
  logic [2:0]        fcnt, fcnt_n;
  logic              rd_en;

  logic [RD_LAT:0]   en_pipe;
  logic [1:0]        r_pipe [RD_LAT];
  logic [1:0]        sel_hold;

  // Rotation is the base-4 digit sum of the butterfly index; the 2-bit
  // accumulator wraps, giving the modulo-4 result directly.
  function automatic logic [1:0] rot(input logic [ADDR_W-1:0] v);
    logic [1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W / 2; i++) acc = acc + v[2*i +: 2];
    return acc;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    b_n     = b;
    s_n     = s;
    fcnt_n  = fcnt;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART) begin
          state_n = RUN;
          b_n     = '0;
          s_n     = '0;
        end
      end
      RUN: begin
        if (!iHOLD) begin
          rd_en = 1'b1;
          b_n   = b + 1'b1;
          if (b == '1) begin
            s_n = s + 4'd1;
            if (s == LAST_STAGE) begin
              state_n = FLUSH;
              s_n     = '0;
              fcnt_n  = '0;
            end
          end
        end
      end
      FLUSH: begin
        if (fcnt == FLUSH_LAST) state_n = DONE;
        else                    fcnt_n  = fcnt + 3'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state <= IDLE;
      b     <= '0;
      s     <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      b     <= b_n;
      s     <= s_n;
      fcnt  <= fcnt_n;
    end
  end

  // Delay lines run every cycle so reads already in flight always land.
  // NOTE: the small delay-line arrays are reset explicitly; an aborted
  // transform must not leak stale valid bits or rotations afterwards.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      en_pipe  <= '0;
      sel_hold <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      for (int i = RD_LAT; i > 0; i--) en_pipe[i] <= en_pipe[i-1];
      en_pipe[0] <= rd_en;
      for (int i = RD_LAT - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
      r_pipe[0] <= rot(b);
      sel_hold  <= oSEL;
    end
  end

  always_comb begin
    oSEL = sel_hold;
    if (en_pipe[RD_LAT-1]) oSEL = r_pipe[RD_LAT-1];
  end

  assign oRD_EN     = rd_en;
  assign oRD_ADDR   = b;
  assign oSTAGE     = s;
  assign oMIX_VALID = en_pipe[RD_LAT];
  assign oBUSY      = (state != IDLE);
  assign oDONE      = (state == DONE);

endmodule

// File: tb/tb_fft_mix_sched.sv
// Bench for fft_mix_sched: two instances (RD_LAT=1 and RD_LAT=3) driven in
// lockstep and compared each cycle against a count-based behavioural model.
module tb_fft_mix_sched;

  localparam int N     = 16;
  localparam int TOTAL = 32;
  localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n, start, hold;

  logic [3:0] addr0, addr1, stage0, stage1;
  logic [1:0] sel0, sel1;
  logic       en0, en1, mix0, mix1, busy0, busy1, done0, done1;

  int tests = 0;
  int fails = 0;
  int cnt_en = 0;
  int cnt_mix = 0;

  int ph [2];
  int n [2];
  int fl [2];
  int exp_sel [2];
  bit en_h [2][8];
  int rot_h [2][8];
  bit just_rst [2];
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  fft_mix_sched #(.ADDR_W(4), .STAGES(2), .RD_LAT(1)) dut0 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iHOLD(hold),
    .oRD_ADDR(addr0), .oRD_EN(en0), .oSEL(sel0), .oMIX_VALID(mix0),
    .oSTAGE(stage0), .oBUSY(busy0), .oDONE(done0)
  );

  fft_mix_sched #(.ADDR_W(4), .STAGES(2), .RD_LAT(3)) dut1 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iHOLD(hold),
    .oRD_ADDR(addr1), .oRD_EN(en1), .oSEL(sel1), .oMIX_VALID(mix1),
    .oSTAGE(stage1), .oBUSY(busy1), .oDONE(done1)
  );

  function automatic int rot4(input int v);
    int acc = 0;
    int x = v;
    while (x > 0) begin
      acc += x % 4;
      x = x / 4;
    end
    return acc % 4;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    ph[d] = P_IDLE;
    n[d] = 0;
    fl[d] = 0;
    exp_sel[d] = 0;
    just_rst[d] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      en_h[d][k] = 1'b0;
      rot_h[d][k] = 0;
    end
  endtask

  task automatic check_dut(input int d);
    bit en_e;
    string p;
    p = (d == 0) ? "lat1" : "lat3";
    en_e = (ph[d] == P_RUN) && !hold;
    check_val({p, "_rd_en"}, (d == 0) ? en0 : en1, en_e);
    check_val({p, "_busy"}, (d == 0) ? busy0 : busy1, ph[d] != P_IDLE);
    check_val({p, "_done"}, (d == 0) ? done0 : done1, ph[d] == P_DONE);
    check_val({p, "_mix_valid"}, (d == 0) ? mix0 : mix1, en_h[d][lat[d] + 1]);
    check_val({p, "_sel"}, (d == 0) ? sel0 : sel1, exp_sel[d]);
    if (ph[d] == P_RUN || just_rst[d]) begin
      check_val({p, "_rd_addr"}, (d == 0) ? addr0 : addr1, n[d] % N);
      check_val({p, "_stage"}, (d == 0) ? stage0 : stage1, n[d] / N);
    end
  endtask

  task automatic model_edge(input int d);
    bit en_e;
    en_e = (ph[d] == P_RUN) && !hold;
    if (!rst_n) begin
      model_reset(d);
    end else begin
      just_rst[d] = 1'b0;
      for (int k = 7; k > 1; k--) begin
        en_h[d][k] = en_h[d][k-1];
        rot_h[d][k] = rot_h[d][k-1];
      end
      en_h[d][1] = en_e;
      rot_h[d][1] = rot4(n[d] % N);
      if (en_h[d][lat[d]]) exp_sel[d] = rot_h[d][lat[d]];
      case (ph[d])
        P_IDLE: if (start) begin
          ph[d] = P_RUN;
          n[d] = 0;
        end
        P_RUN: if (!hold) begin
          n[d]++;
          if (n[d] == TOTAL) begin
            ph[d] = P_FLUSH;
            fl[d] = lat[d] + 1;
          end
        end
        P_FLUSH: begin
          fl[d]--;
          if (fl[d] == 0) ph[d] = P_DONE;
        end
        default: ph[d] = P_IDLE;
      endcase
    end
  endtask

  task automatic step(input logic st, input logic hd, input logic rs);
    start = st;
    hold = hd;
    rst_n = rs;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    if (en0 === 1'b1) cnt_en++;
    if (mix0 === 1'b1) cnt_mix++;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    model_reset(0);
    model_reset(1);
    #1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle_steps(2);

    // Nominal transform
    cnt_en = 0;
    cnt_mix = 0;
    step(1'b1, 1'b0, 1'b1);
    idle_steps(45);
    check_val("nom_rd_en_count", cnt_en, TOTAL);
    check_val("nom_mix_valid_count", cnt_mix, TOTAL);

    // Stall for three cycles at b=5, stage 0
    step(1'b1, 1'b0, 1'b1);
    idle_steps(5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    idle_steps(45);

    // Start requests while busy are ignored, including during DONE
    step(1'b1, 1'b0, 1'b1);
    idle_steps(10);
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (ph[0] != P_DONE && guard < 60) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    check_val("reach_done_within_bound", guard < 60, 1);
    step(1'b1, 1'b0, 1'b1);
    idle_steps(10);

    // Reset at b=9, stage 1, then restart
    step(1'b1, 1'b0, 1'b1);
    idle_steps(25);
    step(1'b0, 1'b0, 1'b0);
    idle_steps(10);
    step(1'b1, 1'b0, 1'b1);
    idle_steps(45);

    // Start held high: transforms run back to back
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 1'b1);
    idle_steps(45);

    // Random start/hold/reset traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 64) != 0);
    idle_steps(45);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
